// File: rtl/mii_rx_framer.sv
// rtl/mii_rx_framer.sv - MII receive framer: preamble/SFD strip, byte assembly, length and CRC-32 checks
`timescale 1ns/1ps

// Reflected CRC-32 (poly 0xEDB88320) advanced over one byte, LSB first
module mii_rx_crc32_step (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);
  // Eight serial shift steps unrolled into a single combinational update
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data_in[i]) begin
        crc_out = (crc_out >> 1) ^ 32'hEDB88320;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end
endmodule

module mii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] phy_rxd,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_err,
  output logic [7:0] rx_mac_data,
  output logic       rx_mac_valid,
  output logic       rx_mac_sof,
  output logic       rx_mac_eof,
  output logic       rx_frame_good,
  output logic       rx_frame_bad,
  output logic [2:0] rx_err_code
);
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DATA_LO, S_DATA_HI, S_DROP
  } state_t;

  localparam logic [LEN_W-1:0] CNT_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CRC  = 3'd1;
  localparam logic [2:0] ERR_RUNT = 3'd2;
  localparam logic [2:0] ERR_OVER = 3'd3;
  localparam logic [2:0] ERR_PHY  = 3'd4;
  localparam logic [2:0] ERR_ODD  = 3'd5;

  state_t           state_q, state_d;
  logic [3:0]       lo_q, lo_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             sof_pend_q, sof_pend_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic             good_q, good_d, bad_q, bad_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       eof_code;
  logic [7:0]       byte_in;

  assign byte_in = {phy_rxd, lo_q};

  mii_rx_crc32_step u_crc (
    .crc_in  (crc_q),
    .data_in (byte_in),
    .crc_out (crc_next)
  );

  // Status for a clean end of frame, first matching cause wins
  always_comb begin
    if (err_q) begin
      eof_code = ERR_PHY;
    end else if (cnt_q > CNT_MAX) begin
      eof_code = ERR_OVER;
    end else if (cnt_q < CNT_MIN) begin
      eof_code = ERR_RUNT;
    end else if (crc_q != CRC_RESIDUE) begin
      eof_code = ERR_CRC;
    end else begin
      eof_code = ERR_NONE;
    end
  end

  // Next state, datapath updates and registered stream/status outputs
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sof_pend_d = sof_pend_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    data_d     = 8'h00;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    code_d     = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (phy_rx_dv) state_d = (phy_rxd == 4'h5) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end else if (phy_rxd == 4'hD) begin
          state_d    = S_DATA_LO;
          hold_vld_d = 1'b0;
          sof_pend_d = 1'b1;
          err_d      = 1'b0;
          cnt_d      = '0;
          crc_d      = CRC_INIT;
        end else if (phy_rxd != 4'h5) begin
          state_d = S_DROP;
        end
      end
      S_DATA_LO: begin
        if (phy_rx_dv) begin
          lo_d    = phy_rxd;
          err_d   = err_q | phy_rx_err;
          state_d = S_DATA_HI;
        end else begin
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            data_d     = hold_q;
            valid_d    = 1'b1;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
            eof_d      = 1'b1;
            code_d     = eof_code;
            good_d     = (eof_code == ERR_NONE);
            bad_d      = (eof_code != ERR_NONE);
          end
        end
      end
      S_DATA_HI: begin
        if (phy_rx_dv) begin
          err_d      = err_q | phy_rx_err;
          hold_d     = byte_in;
          hold_vld_d = 1'b1;
          crc_d      = crc_next;
          cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
          state_d    = S_DATA_LO;
          if (hold_vld_q) begin
            data_d     = hold_q;
            valid_d    = 1'b1;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
          end
        end else begin
          // Odd nibble count; a phy error seen earlier still takes priority
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            data_d     = hold_q;
            valid_d    = 1'b1;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
            eof_d      = 1'b1;
            bad_d      = 1'b1;
            code_d     = err_q ? ERR_PHY : ERR_ODD;
          end
        end
      end
      S_DROP: begin
        if (!phy_rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q       <= 4'h0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      sof_pend_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      lo_q       <= lo_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sof_pend_q <= sof_pend_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      code_q     <= code_d;
    end
  end

  assign rx_mac_data   = data_q;
  assign rx_mac_valid  = valid_q;
  assign rx_mac_sof    = sof_q;
  assign rx_mac_eof    = eof_q;
  assign rx_frame_good = good_q;
  assign rx_frame_bad  = bad_q;
  assign rx_err_code   = code_q;
endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
Receive-side MII framer between the PHY receive pins and the per-port transmit FIFO. It runs on the PHY receive clock and strips preamble and SFD. It assembles nibbles into bytes, checks length and CRC-32, and presents a byte stream with frame delimiters and end-of-frame status. The FIFO write logic consumes this stream and uses the status to commit or discard each frame.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS inclusive)
LEN_W, 11, width of the internal byte counter; must satisfy 2^LEN_W > MAX_LEN

Ports:
clk  in  1  PHY receive clock (phy_rx_clk); every sequential element uses its rising edge
rst_n  in  1  asynchronous active-low reset
phy_rxd  in  4  MII receive nibble
phy_rx_dv  in  1  MII receive data valid
phy_rx_err  in  1  MII receive error
rx_mac_data  out  8  assembled frame byte
rx_mac_valid  out  1  rx_mac_data valid this cycle
rx_mac_sof  out  1  first byte of frame (DA byte 0); qualified by rx_mac_valid
rx_mac_eof  out  1  last byte of frame (FCS byte 3); qualified by rx_mac_valid
rx_frame_good  out  1  one-cycle pulse with eof: frame passed all checks
rx_frame_bad  out  1  one-cycle pulse: frame failed; rx_err_code is valid in the same cycle
rx_err_code  out  3  failure cause: 1=CRC, 2=runt, 3=oversize, 4=phy_rx_err, 5=odd nibble

Behaviour:
- Reset: all outputs are 0, state is IDLE, CRC register is 0xFFFFFFFF, byte counter is 0, holding register is empty. Reset asserted mid-frame abandons the frame; no eof, good or bad pulse is issued for it.
- MII nibble order: low nibble first. Byte = {second nibble, first nibble}.
- IDLE: when phy_rx_dv=1 and phy_rxd=0x5, go to PREAMBLE. Any other nibble with dv=1 goes to DROP.
- PREAMBLE:
  - rxd=0x5: stay.
  - rxd=0xD (SFD high nibble): go to DATA_LO.
  - Any other nibble: go to DROP.
  - dv=0: go to IDLE silently.
- DATA_LO: latch the low nibble and go to DATA_HI. dv=0 here marks a clean end of frame and runs the EOF processing below.
- DATA_HI: form the byte, advance the CRC over it, increment the byte counter (saturating at MAX_LEN+1), and go to DATA_LO. dv=0 here means an odd nibble count: go to IDLE and apply the odd-nibble error in the EOF rules.
- One-byte holding delay:
  - Each completed byte is written into the holding register.
  - The previously held byte is output with rx_mac_valid=1 in the cycle after the new byte's high nibble is sampled.
  - rx_mac_sof is set on the first output byte of the frame.
- EOF processing (dv falls in DATA_LO): in the next cycle, output the held byte with rx_mac_valid=1 and rx_mac_eof=1. In that same cycle, pulse exactly one of rx_frame_good or rx_frame_bad, then go to IDLE.
- Error priority at EOF (first match wins):
  1. phy_rx_err seen during the frame: code 4.
  2. Odd nibble: code 5.
  3. Oversize (count > MAX_LEN): code 3.
  4. Runt (count < MIN_LEN): code 2.
  5. CRC mismatch: code 1.
- Odd-nibble end (dv falls in DATA_HI): the held byte is output with eof=1 and rx_frame_bad=1, code 5.
- phy_rx_err=1 while dv=1 in DATA_LO or DATA_HI: set a sticky error flag and keep receiving bytes. The frame ends bad with code 4.
- CRC: reflected CRC-32, polynomial 0xEDB88320, processed LSB-first, init 0xFFFFFFFF. It runs over every byte after the SFD, FCS bytes included. The frame is good iff the register equals the residue 0xDEBB20E3 after the last byte.
- Oversize does not truncate the stream: bytes continue to be output until dv falls. The counter saturates, so it never wraps.
- DROP: output nothing until dv=0, then go to IDLE. No status pulse is issued, because no sof was emitted.
- Frames shorter than one byte after the SFD produce no output and no pulses.
- Back-to-back frames:
  - dv=0 for one cycle is enough to return to IDLE.
  - The EOF output cycle overlaps IDLE sampling of the next preamble.
  - sof/eof of consecutive frames never coincide.
- Latency: from the high-nibble sample of byte N to the rx_mac_valid of byte N-1 is one cycle. The last byte appears one cycle after dv falls.

Test Plan:
- 64-byte frame (60 data bytes + correct FCS) after 7×0x55 + 0xD5 -> 64 valid bytes; sof on byte 0; eof on byte 63; rx_frame_good=1; no bad pulse.
- Same frame with FCS byte 2 XOR 0x01 -> 64 bytes; eof; rx_frame_bad=1; rx_err_code=1.
- 60-byte frame with valid FCS -> rx_frame_bad=1, code=2. A 1519-byte frame -> 1519 bytes output, code=3.
- phy_rx_err pulsed for one cycle at byte 20 of a 100-byte good-FCS frame -> 100 bytes output; bad pulse; code=4.
- dv drops after a lone low nibble at the end of a 64-byte frame -> eof on byte 63; bad pulse; code=5.
- Preamble 0x5,0x5,0x3 (no SFD) -> no output. rst_n low at byte 30 of a frame -> outputs 0 immediately; the next frame is received good.
